// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key-code helper for the keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned KEY_W    = 4;

    // Frame result meaning "no key seen"; never presented on key_code.
    localparam logic [KEY_W-1:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } deb_state_e;

    // Linear key code: row*3 + col.
    function automatic logic [KEY_W-1:0] key_of(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the column inputs; resets to the idle (all ones) level.
module sync_2ff
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] d,
    output logic [NUM_COLS-1:0] q
);

    logic [NUM_COLS-1:0] meta_q;

    // Two-stage capture of the asynchronous pin levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            q      <= '1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x3 keypad initiator with frame-based debounce and press events.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [NUM_COLS-1:0] in_from_keypad,
    output logic [NUM_ROWS-1:0] out_to_keypad,
    output logic                key_valid,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_CNT    = 4'(DEBOUNCE_SCANS);

    logic [NUM_COLS-1:0] col_sync;
    logic [NUM_COLS-1:0] col_act;
    logic [DIV_W-1:0]    dwell_q;
    logic [1:0]          row_q;
    logic [KEY_W-1:0]    acc_q;
    logic [KEY_W-1:0]    cand_q;
    logic [3:0]          cnt_q;
    deb_state_e          state_q;

    logic                sample_en;
    logic                frame_end;
    logic                row_hit;
    logic [KEY_W-1:0]    row_code;
    logic [KEY_W-1:0]    frame_code;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_from_keypad),
        .q   (col_sync)
    );

    assign col_act   = ~col_sync;
    assign sample_en = scan_en && (dwell_q == DWELL_LAST);
    assign frame_end = sample_en && (row_q == 2'd3);

    // All rows released while frozen so the matrix is not driven.
    assign out_to_keypad = scan_en ? ~(4'b0001 << row_q) : 4'b1111;

    // Lowest pressed column in the row currently being sampled.
    always_comb begin
        row_hit  = 1'b0;
        row_code = KEY_NONE;
        for (int c = int'(NUM_COLS) - 1; c >= 0; c--) begin
            if (col_act[c]) begin
                row_hit  = 1'b1;
                row_code = key_of(row_q, 2'(c));
            end
        end
    end

    // Earlier rows win, so a recorded code is never overwritten within a frame.
    assign frame_code = (acc_q != KEY_NONE) ? acc_q : (row_hit ? row_code : KEY_NONE);

    // Dwell and row sequencing; while frozen the dwell is parked at 0 so the
    // current row gets its full settle time once scanning resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
            row_q   <= 2'd0;
        end else if (!scan_en) begin
            dwell_q <= '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            row_q   <= row_q + 2'd1;
        end else begin
            dwell_q <= dwell_q + DIV_W'(1);
        end
    end

    // Frame accumulator: keep the first (lowest) code, clear at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= KEY_NONE;
        end else if (sample_en) begin
            acc_q <= frame_end ? KEY_NONE : frame_code;
        end
    end

    // Debounce FSM, evaluated once per frame end, with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= KEY_NONE;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    IDLE: begin
                        if (frame_code != KEY_NONE) begin
                            cand_q <= frame_code;
                            cnt_q  <= 4'd1;
                            if (DEB_CNT == 4'd1) begin
                                state_q   <= HELD;
                                key_code  <= frame_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state_q <= DEB_PRESS;
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (frame_code == KEY_NONE) begin
                            state_q <= IDLE;
                        end else if (frame_code == cand_q) begin
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q + 4'd1 >= DEB_CNT) begin
                                state_q   <= HELD;
                                key_code  <= cand_q;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else begin
                            cand_q <= frame_code;
                            cnt_q  <= 4'd1;
                        end
                    end
                    HELD: begin
                        if (frame_code != key_code) begin
                            cnt_q <= 4'd1;
                            if (DEB_CNT == 4'd1) begin
                                state_q  <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state_q <= DEB_REL;
                            end
                        end
                    end
                    DEB_REL: begin
                        if (frame_code == key_code) begin
                            state_q <= HELD;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q + 4'd1 >= DEB_CNT) begin
                                state_q  <= IDLE;
                                key_held <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        key_held <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: vector table, hand sequences, random frames.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_en = 1'b1;
    logic [2:0]  pins;
    logic [3:0]  out_to_keypad;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [11:0] keys = '0;

    int total = 0;
    int bad   = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .scan_en        (scan_en),
        .in_from_keypad (pins),
        .out_to_keypad  (out_to_keypad),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_held       (key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to a driven (low) row.
    always_comb begin
        pins = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!out_to_keypad[r] && keys[r*3+c]) pins[c] = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: acceptance = DEB identical non-empty frames in a row while
    // not holding; release = DEB frames in a row that differ from the held key.
    int m_held, m_code, m_run_key, m_run_len, m_rel;
    bit m_valid;

    task automatic model_reset();
        m_held = -1; m_code = 0; m_run_key = -1; m_run_len = 0; m_rel = 0; m_valid = 0;
    endtask

    task automatic model_frame(input logic [11:0] k);
        int fr;
        fr = -1;
        for (int j = 11; j >= 0; j--) if (k[j]) fr = j;
        m_valid = 0;
        if (m_held < 0) begin
            if (fr < 0) m_run_len = 0;
            else if (m_run_len > 0 && fr == m_run_key) m_run_len++;
            else begin
                m_run_key = fr;
                m_run_len = 1;
            end
            if (m_run_len >= DEB) begin
                m_held = fr; m_code = fr; m_valid = 1; m_run_len = 0; m_rel = 0;
            end
        end else begin
            if (fr == m_held) m_rel = 0;
            else m_rel++;
            if (m_rel >= DEB) begin
                m_held = -1; m_run_len = 0; m_rel = 0;
            end
        end
    endtask

    // Runs one whole frame from its cycle 0; returns at cycle 0 of the next frame.
    task automatic run_frame(input logic [11:0] k);
        int row_err, pulses;
        logic [3:0] exp_row;
        row_err = 0;
        pulses  = 0;
        keys    = k;
        for (int i = 0; i < FRAME; i++) begin
            exp_row = ~(4'b0001 << (i / SCAN_DIV));
            if (out_to_keypad !== exp_row) row_err++;
            if (i > 0 && key_valid) pulses++;
            step();
        end
        check("row_sequence_errors", row_err, 0);
        check("pulse_mid_frame", pulses, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [11:0] keys;
        bit          valid;
        int          code;
        bit          held;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [11:0] k, input bit v, input int c, input bit h);
        vec_t e;
        e.keys = k; e.valid = v; e.code = c; e.held = h;
        tbl.push_back(e);
    endfunction

    localparam logic [11:0] K7  = 12'h080;
    localparam logic [11:0] K4  = 12'h010;
    localparam logic [11:0] K5A = 12'h420;

    initial begin
        int frz_err;

        // Idle scan, single press, partial release, full release.
        add(12'h000, 0, 0, 0);
        add(K7, 0, 0, 0); add(K7, 0, 0, 0); add(K7, 1, 7, 1);
        add(12'h000, 0, 7, 1); add(12'h000, 0, 7, 1); add(K7, 0, 7, 1);
        add(12'h000, 0, 7, 1); add(12'h000, 0, 7, 1); add(12'h000, 0, 7, 0);
        // Bounce on key 4.
        for (int i = 0; i < 3; i++) begin
            add(K4, 0, 7, 0);
            add(12'h000, 0, 7, 0);
        end
        // Keys 5 and 10 together, then release.
        add(K5A, 0, 7, 0); add(K5A, 0, 7, 0); add(K5A, 1, 5, 1);
        add(12'h000, 0, 5, 1); add(12'h000, 0, 5, 1); add(12'h000, 0, 5, 0);

        scan_en = 1'b1;
        rst     = 1'b1;
        step(); step(); step();
        check("reset_rows", int'(out_to_keypad), 4'b1110);
        check("reset_valid", int'(key_valid), 0);
        check("reset_code", int'(key_code), 0);
        check("reset_held", int'(key_held), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_frame(tbl[i].keys);
            check($sformatf("tbl%0d_valid", i), int'(key_valid), int'(tbl[i].valid));
            check($sformatf("tbl%0d_code", i), int'(key_code), tbl[i].code);
            check($sformatf("tbl%0d_held", i), int'(key_held), int'(tbl[i].held));
        end

        // Freeze mid-row 2 while debouncing key 7.
        do_reset();
        run_frame(K7);
        check("frz_pre_held", int'(key_held), 0);
        keys = K7;
        for (int i = 0; i < 20; i++) step();
        check("frz_row2", int'(out_to_keypad), 4'b1011);
        scan_en = 1'b0;
        frz_err = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_to_keypad !== 4'b1111 || key_valid !== 1'b0 || key_held !== 1'b0) frz_err++;
        end
        check("frz_outputs_errors", frz_err, 0);
        scan_en = 1'b1;
        #1;
        check("frz_resume_row", int'(out_to_keypad), 4'b1011);
        frz_err = 0;
        for (int i = 0; i < 2 * SCAN_DIV; i++) begin
            if (key_valid) frz_err++;
            step();
        end
        check("frz_no_early_pulse", frz_err, 0);
        check("frz_frame_wrap", int'(out_to_keypad), 4'b1110);
        check("frz_valid_after2", int'(key_valid), 0);
        run_frame(K7);
        check("frz_accept_valid", int'(key_valid), 1);
        check("frz_accept_code", int'(key_code), 7);
        check("frz_accept_held", int'(key_held), 1);

        // Release to IDLE, start debouncing key 4, then reset mid-frame.
        for (int i = 0; i < 3; i++) run_frame(12'h000);
        check("rst_pre_held", int'(key_held), 0);
        run_frame(K4);
        check("rst_debpress_held", int'(key_held), 0);
        for (int i = 0; i < 15; i++) step();
        rst = 1'b1;
        frz_err = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (key_valid !== 1'b0) frz_err++;
        end
        check("rst_no_pulse", frz_err, 0);
        check("rst_rows", int'(out_to_keypad), 4'b1110);
        check("rst_code", int'(key_code), 0);
        check("rst_held", int'(key_held), 0);
        rst = 1'b0;
        run_frame(K4);
        run_frame(K4);
        check("rst_progress_lost", int'(key_valid), 0);
        run_frame(K4);
        check("rst_reaccept_valid", int'(key_valid), 1);
        check("rst_reaccept_code", int'(key_code), 4);

        // Random frame sequences against the reference model.
        do_reset();
        model_reset();
        keys = '0;
        for (int f = 0; f < 40; f++) begin
            logic [11:0] k;
            int r;
            k = keys;
            r = int'($urandom_range(0, 99));
            if (r >= 55 && r < 70) k = '0;
            else if (r >= 70 && r < 93) k = 12'(1) << $urandom_range(0, 11);
            else if (r >= 93) k = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
            run_frame(k);
            model_frame(k);
            check($sformatf("rnd%0d_valid", f), int'(key_valid), int'(m_valid));
            check($sformatf("rnd%0d_code", f), int'(key_code), m_code);
            check($sformatf("rnd%0d_held", f), int'(key_held), (m_held >= 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning initiator for the 4×3 matrix keypad. It drives `out_to_keypad` one row at a time and samples the active-low `in_from_keypad` columns. It debounces the result over whole scan frames and emits one-cycle key-press events with a 4-bit key code. It sits between the keypad pins and the input manager in `top`, and replaces the pattern-injection path the benches currently use.

## Interface
- `SCAN_DIV`, 50000: clock cycles each row is driven (1 ms at 50 MHz); legal minimum is 4.
- `DEBOUNCE_SCANS`, 3: number of consecutive identical frames needed to accept a press or a release; legal range 1–15.

- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `scan_en` in 1: enables scanning; when low, the block is frozen as described under Operation.
- `in_from_keypad` in 3: column inputs, active-low; bit c is column c; idle value is 3'b111.
- `out_to_keypad` out 4: row drive, active-low one-hot; bit r is row r.
- `key_valid` out 1: one-cycle pulse marking an accepted press.
- `key_code` out 4: code of the accepted key, computed as row*3 + col (range 0–11); holds its value until the next accepted press.
- `key_held` out 1: high while the accepted key remains debounced-pressed.

## Operation
- **Column sync:** `in_from_keypad` passes through a 2-flop synchronizer and is inverted to active-high before use.
- **Row sequencing:**
  - A dwell counter runs 0..SCAN_DIV-1; the row index runs 0..3 and wraps 3→0.
  - `out_to_keypad` = ~(4'b0001 << row).
  - Columns are sampled only on the cycle where dwell = SCAN_DIV-1 (the last cycle of the row), so the settle time is SCAN_DIV-3 cycles.
- **Frame accumulation:**
  - Across rows 0–3, the block records the lowest pressed code (lowest row first, then lowest column).
  - If several keys are down, the lowest code wins.
  - If no key is down, the frame result is NONE.
  - The frame ends at the row-3 sample cycle; the accumulator clears for the next frame.
- **Debounce FSM:** states IDLE, DEB_PRESS, HELD, DEB_REL, evaluated once per frame end. `cnt` counts matching frames; `cand` is the candidate code.
  - **IDLE:**
    - frame = key k → `cand` = k, `cnt` = 1, go to DEB_PRESS.
    - If DEBOUNCE_SCANS = 1, go directly to HELD and accept k.
  - **DEB_PRESS:**
    - frame = `cand` → `cnt`++; when `cnt` reaches DEBOUNCE_SCANS, accept `cand` and go to HELD.
    - frame = other key j → `cand` = j, `cnt` = 1.
    - frame = NONE → IDLE.
  - **HELD:**
    - frame = `key_code` → stay.
    - frame = anything else → `cnt` = 1, go to DEB_REL (or IDLE if DEBOUNCE_SCANS = 1).
  - **DEB_REL:**
    - frame ≠ `key_code` → `cnt`++; when `cnt` reaches DEBOUNCE_SCANS, go to IDLE.
    - frame = `key_code` → back to HELD.
  - A different key pressed while HELD must pass through release debounce before it can be accepted.
- **Accept:** `key_code` ← `cand`, `key_valid` pulses, `key_held` = 1.
- **`key_held`:** high in HELD and DEB_REL; low in IDLE and DEB_PRESS.
- **`scan_en` low:**
  - The dwell counter, row index, frame accumulator and FSM hold their values.
  - `out_to_keypad` = 4'b1111; `key_valid` = 0; `key_held` and `key_code` hold.
  - When `scan_en` rises, the current row's dwell restarts from 0 so the settle time is honoured.

## Timing
- **Reset values:** `out_to_keypad` = 4'b1110, dwell = 0, row = 0, FSM = IDLE, `cnt` = 0, `key_valid` = 0, `key_code` = 4'h0, `key_held` = 0, synchronizer flops = 3'b111.
- **Reset mid-frame:** discards the partial frame and any debounce progress; no `key_valid` is emitted on reset.
- **Frame length:** 4·SCAN_DIV cycles.
- **Output update:** the FSM and outputs update on the clock edge after the row-3 sample cycle.
- **Press latency:** `key_valid` rises one cycle after the row-3 sample of the DEBOUNCE_SCANS-th consecutive matching frame, and lasts exactly 1 cycle.
- **Sample qualification:** a column level must be present at the pin at least 2 cycles before the sample cycle to be seen.

## Structure
- **Package `keypad_pkg`:**
  - NUM_ROWS = 4, NUM_COLS = 3.
  - Key-code width 4; KEY_NONE = 4'hF, used for the internal frame result only.
  - FSM state typedef {IDLE, DEB_PRESS, HELD, DEB_REL}.
- **Sub-module `sync_2ff`:** 3-bit wide, reset to all ones.

## Test plan
All scenarios use SCAN_DIV = 8 and DEBOUNCE_SCANS = 3, giving a 32-cycle frame.
1. **Reset and idle:** hold columns at 3'b111 → `out_to_keypad` cycles 1110, 1101, 1011, 0111 every 8 cycles; `key_valid` never asserts.
2. **Single press:** pull column 1 low only while row 2 is driven, for 3 full frames → `key_valid` pulses once with `key_code` = 7, one cycle after the third frame's row-3 sample; `key_held` = 1.
3. **Bounce:** toggle key 4 present/absent on alternate frames for 6 frames → no `key_valid`; the FSM never leaves IDLE/DEB_PRESS.
4. **Release:** after scenario 2, release for 2 frames and then re-press → `key_held` stays 1 and there is no second `key_valid`. Release for 3 frames → `key_held` falls.
5. **Multi-key:** hold keys 5 and 10 together for 3 frames → `key_code` = 5.
6. **Freeze and reset:** drop `scan_en` mid-row 2 → `out_to_keypad` = 4'b1111 and the state holds. Assert `rst` during DEB_PRESS → all outputs return to their reset values and no pulse is emitted.
